// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard sequencer.
// Pure declarations, no logic and no latency.
// No flow control of its own.
package pipeline_hazard_ctrl_pkg;

  // Sequencer states; MEM_WAIT remembers where to resume.
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } state_t;

  // EX operand mux selects.
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Width of the load-stall / flush down-counter (both limited to 1..3).
  localparam int unsigned SEQ_CNT_W = 2;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Forwarding select for one EX operand: MEM result beats WB result beats register file.
// Purely combinational, zero cycles.
// No backpressure; output follows inputs every cycle.
import pipeline_hazard_ctrl_pkg::*;

module pipeline_hazard_ctrl_fwd_select (
  input  logic [3:0] i_src_addr,
  input  logic [3:0] i_mem_w_addr,
  input  logic       i_mem_reg_write,
  input  logic [3:0] i_wb_w_addr,
  input  logic       i_wb_reg_write,
  output logic [1:0] o_fwd
);

  // Youngest producer wins; register 0 is an ordinary register here.
  always_comb begin
    o_fwd = FWD_RF;
    if (i_mem_reg_write && (i_mem_w_addr == i_src_addr)) begin
      o_fwd = FWD_EXMEM;
    end else if (i_wb_reg_write && (i_wb_w_addr == i_src_addr)) begin
      o_fwd = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer: stalls on load-use, flushes IF/ID on taken branch, freezes on mem_busy, selects forwarding.
// Controls are combinational from state and inputs (act in the detection cycle); state updates next edge.
// mem_busy freezes the whole pipe and pre-empts any stall or flush in progress.
import pipeline_hazard_ctrl_pkg::*;

module pipeline_hazard_ctrl #(
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       id_a_addr,
  input  logic [3:0]       id_b_addr,
  input  logic             id_uses_a,
  input  logic             id_uses_b,
  input  logic [3:0]       ex_w_addr,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [3:0]       mem_w_addr,
  input  logic             mem_reg_write,
  input  logic [3:0]       wb_w_addr,
  input  logic             wb_reg_write,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [SEQ_CNT_W-1:0] LS_INIT = SEQ_CNT_W'(LOAD_LATENCY - 1);
  localparam logic [SEQ_CNT_W-1:0] FL_INIT = SEQ_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t               r_state;
  state_t               r_resume;
  logic [SEQ_CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0]     r_stall_count;

  state_t               w_state_nxt;
  state_t               w_resume_nxt;
  state_t               w_eff;
  logic [SEQ_CNT_W-1:0] w_cnt_nxt;
  logic                 w_load_use;

  assign w_load_use = ex_mem_read & ex_reg_write &
                      ((id_uses_a & (id_a_addr == ex_w_addr)) |
                       (id_uses_b & (id_b_addr == ex_w_addr)));

  assign stall_count = r_stall_count;

  pipeline_hazard_ctrl_fwd_select u_fwd_a (
    .i_src_addr      (id_a_addr),
    .i_mem_w_addr    (mem_w_addr),
    .i_mem_reg_write (mem_reg_write),
    .i_wb_w_addr     (wb_w_addr),
    .i_wb_reg_write  (wb_reg_write),
    .o_fwd           (fwd_a)
  );

  pipeline_hazard_ctrl_fwd_select u_fwd_b (
    .i_src_addr      (id_b_addr),
    .i_mem_w_addr    (mem_w_addr),
    .i_mem_reg_write (mem_reg_write),
    .i_wb_w_addr     (wb_w_addr),
    .i_wb_reg_write  (wb_reg_write),
    .o_fwd           (fwd_b)
  );

  // Next-state and Mealy control outputs; MEM_WAIT acts as its resume state once memory is ready.
  always_comb begin
    pc_enable    = 1'b1;
    if_id_enable = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    w_state_nxt  = r_state;
    w_resume_nxt = r_resume;
    w_cnt_nxt    = r_cnt;
    w_eff        = ((r_state == MEM_WAIT) && !mem_busy) ? r_resume : r_state;

    if (!reset) begin
      case (w_eff)
        RUN: begin
          if (mem_busy) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            w_state_nxt  = MEM_WAIT;
            w_resume_nxt = RUN;
          end else begin
            w_state_nxt = RUN;
            if (branch_taken) begin
              // The ID instruction is discarded, so a coincident load-use needs no bubble.
              if_id_flush = 1'b1;
              if (FLUSH_CYCLES > 1) begin
                w_state_nxt = FLUSH;
                w_cnt_nxt   = FL_INIT;
              end
            end else if (w_load_use) begin
              pc_enable    = 1'b0;
              if_id_enable = 1'b0;
              id_ex_bubble = 1'b1;
              if (LOAD_LATENCY > 1) begin
                w_state_nxt = LOAD_STALL;
                w_cnt_nxt   = LS_INIT;
              end
            end
          end
        end
        LOAD_STALL: begin
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          if (mem_busy) begin
            // The load completes during the freeze; remaining stall cycles are moot.
            w_state_nxt  = MEM_WAIT;
            w_resume_nxt = RUN;
            w_cnt_nxt    = '0;
          end else begin
            id_ex_bubble = 1'b1;
            w_cnt_nxt    = r_cnt - 1'b1;
            w_state_nxt  = (r_cnt <= 1) ? RUN : LOAD_STALL;
          end
        end
        FLUSH: begin
          if (mem_busy) begin
            // Freeze with the counter held so the flush picks up where it left off.
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            w_state_nxt  = MEM_WAIT;
            w_resume_nxt = FLUSH;
          end else begin
            if_id_flush = 1'b1;
            w_cnt_nxt   = r_cnt - 1'b1;
            w_state_nxt = (r_cnt <= 1) ? RUN : FLUSH;
          end
        end
        default: begin
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state, resume target and down-counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= RUN;
      r_resume <= RUN;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_resume <= w_resume_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Debug count of PC-frozen cycles, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (!pc_enable && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl over three parameterisations sharing one stimulus.
// Inputs change just after the falling edge; outputs are sampled 1 ns later, away from the rising edge.
// Expected values are hand-computed constants.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] id_a_addr, id_b_addr, ex_w_addr, mem_w_addr, wb_w_addr;
  logic       id_uses_a, id_uses_b, ex_reg_write, ex_mem_read;
  logic       mem_reg_write, wb_reg_write, branch_taken, mem_busy;

  // d0: LOAD_LATENCY=1 FLUSH_CYCLES=1 CNT_W=8
  logic       d0_pc, d0_ifid, d0_flush, d0_bub;
  logic [1:0] d0_fa, d0_fb;
  logic [7:0] d0_cnt;
  // d1: LOAD_LATENCY=3 FLUSH_CYCLES=2 CNT_W=8
  logic       d1_pc, d1_ifid, d1_flush, d1_bub;
  logic [1:0] d1_fa, d1_fb;
  logic [7:0] d1_cnt;
  // d2: LOAD_LATENCY=3 FLUSH_CYCLES=3 CNT_W=4
  logic       d2_pc, d2_ifid, d2_flush, d2_bub;
  logic [1:0] d2_fa, d2_fb;
  logic [3:0] d2_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LOAD_LATENCY(1), .FLUSH_CYCLES(1), .CNT_W(8)) u_dut0 (
    .clk(clk), .reset(reset), .id_a_addr(id_a_addr), .id_b_addr(id_b_addr),
    .id_uses_a(id_uses_a), .id_uses_b(id_uses_b), .ex_w_addr(ex_w_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .mem_w_addr(mem_w_addr),
    .mem_reg_write(mem_reg_write), .wb_w_addr(wb_w_addr), .wb_reg_write(wb_reg_write),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .pc_enable(d0_pc),
    .if_id_enable(d0_ifid), .if_id_flush(d0_flush), .id_ex_bubble(d0_bub),
    .fwd_a(d0_fa), .fwd_b(d0_fb), .stall_count(d0_cnt));

  pipeline_hazard_ctrl #(.LOAD_LATENCY(3), .FLUSH_CYCLES(2), .CNT_W(8)) u_dut1 (
    .clk(clk), .reset(reset), .id_a_addr(id_a_addr), .id_b_addr(id_b_addr),
    .id_uses_a(id_uses_a), .id_uses_b(id_uses_b), .ex_w_addr(ex_w_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .mem_w_addr(mem_w_addr),
    .mem_reg_write(mem_reg_write), .wb_w_addr(wb_w_addr), .wb_reg_write(wb_reg_write),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .pc_enable(d1_pc),
    .if_id_enable(d1_ifid), .if_id_flush(d1_flush), .id_ex_bubble(d1_bub),
    .fwd_a(d1_fa), .fwd_b(d1_fb), .stall_count(d1_cnt));

  pipeline_hazard_ctrl #(.LOAD_LATENCY(3), .FLUSH_CYCLES(3), .CNT_W(4)) u_dut2 (
    .clk(clk), .reset(reset), .id_a_addr(id_a_addr), .id_b_addr(id_b_addr),
    .id_uses_a(id_uses_a), .id_uses_b(id_uses_b), .ex_w_addr(ex_w_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .mem_w_addr(mem_w_addr),
    .mem_reg_write(mem_reg_write), .wb_w_addr(wb_w_addr), .wb_reg_write(wb_reg_write),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .pc_enable(d2_pc),
    .if_id_enable(d2_ifid), .if_id_flush(d2_flush), .id_ex_bubble(d2_bub),
    .fwd_a(d2_fa), .fwd_b(d2_fb), .stall_count(d2_cnt));

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    id_a_addr = 4'h0; id_b_addr = 4'h0; id_uses_a = 1'b0; id_uses_b = 1'b0;
    ex_w_addr = 4'h0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_w_addr = 4'h0; mem_reg_write = 1'b0; wb_w_addr = 4'h0; wb_reg_write = 1'b0;
    branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic load_use_a3();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_w_addr = 4'h3;
    id_a_addr = 4'h3; id_uses_a = 1'b1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    clr();
    reset = 1'b1;

    // Reset dominates mem_busy: outputs stay in their reset values.
    next_cycle(); mem_busy = 1'b1; #1;
    check("rst_pc", d0_pc, 1);
    check("rst_ifid", d0_ifid, 1);
    check("rst_flush", d0_flush, 0);
    check("rst_bub", d0_bub, 0);
    check("rst_fwd_a", d0_fa, 0);
    check("rst_fwd_b", d0_fb, 0);
    next_cycle(); #1;
    check("rst_pc_d2", d2_pc, 1);

    next_cycle(); reset = 1'b0; clr(); #1;
    check("rst_cnt_d0", d0_cnt, 0);
    check("rst_cnt_d2", d2_cnt, 0);
    check("idle_pc", d0_pc, 1);

    // Load-use qualified by uses flag and reg_write.
    next_cycle(); load_use_a3(); id_uses_a = 1'b0; #1;
    check("lu_nouse_pc", d0_pc, 1);
    id_uses_a = 1'b1; ex_reg_write = 1'b0; #1;
    check("lu_nowr_pc", d0_pc, 1);

    // Load-use: 1 cycle on d0, 3 cycles on d1/d2.
    next_cycle(); clr(); load_use_a3(); #1;
    check("lu_pc", d0_pc, 0);
    check("lu_ifid", d0_ifid, 0);
    check("lu_bub", d0_bub, 1);
    check("lu_pc_d1", d1_pc, 0);
    next_cycle(); clr(); #1;
    check("lu_done_pc", d0_pc, 1);
    check("lu_done_bub", d0_bub, 0);
    check("lu_cnt_d0", d0_cnt, 1);
    check("lu3_c2_pc", d1_pc, 0);
    check("lu3_c2_bub", d1_bub, 1);
    next_cycle(); #1;
    check("lu3_c3_pc", d1_pc, 0);
    check("lu3_c3_ifid", d2_ifid, 0);
    next_cycle(); #1;
    check("lu3_done_pc", d1_pc, 1);
    check("lu3_cnt_d1", d1_cnt, 3);
    check("lu3_cnt_d2", d2_cnt, 3);

    // Forwarding priority on operand B, A stays on register file.
    next_cycle(); mem_w_addr = 4'h5; wb_w_addr = 4'h5; mem_reg_write = 1'b1;
    wb_reg_write = 1'b1; id_b_addr = 4'h5; id_a_addr = 4'h9; #1;
    check("fwd_b_mem", d0_fb, 1);
    check("fwd_a_rf", d0_fa, 0);
    mem_reg_write = 1'b0; #1;
    check("fwd_b_wb", d1_fb, 2);
    wb_w_addr = 4'h6; #1;
    check("fwd_b_rf", d2_fb, 0);
    id_a_addr = 4'h6; #1;
    check("fwd_a_wb", d1_fa, 2);
    mem_reg_write = 1'b1; mem_w_addr = 4'h0; id_a_addr = 4'h0; #1;
    check("fwd_a_r0", d2_fa, 1);
    check("fwd_pc", d0_pc, 1);

    // Branch + load-use in the same cycle: flush wins, no bubble.
    next_cycle(); clr(); load_use_a3(); branch_taken = 1'b1; #1;
    check("br_flush", d0_flush, 1);
    check("br_bub", d0_bub, 0);
    check("br_pc", d0_pc, 1);
    check("br_bub_d1", d1_bub, 0);
    next_cycle(); clr(); #1;
    check("br_d0_done", d0_flush, 0);
    check("br2_c2_flush", d1_flush, 1);
    check("br2_c2_pc", d1_pc, 1);
    check("br3_c2_flush", d2_flush, 1);
    next_cycle(); #1;
    check("br2_done", d1_flush, 0);
    check("br3_c3_flush", d2_flush, 1);
    next_cycle(); #1;
    check("br3_done", d2_flush, 0);

    // mem_busy for 4 cycles after 1 flush cycle on d2 (FLUSH_CYCLES=3).
    next_cycle(); branch_taken = 1'b1; #1;
    check("fb_c1_flush", d2_flush, 1);
    for (int i = 0; i < 4; i++) begin
      next_cycle(); clr(); mem_busy = 1'b1; #1;
      check("fb_frz_pc", d2_pc, 0);
      check("fb_frz_flush", d2_flush, 0);
    end
    next_cycle(); clr(); #1;
    check("fb_res1_flush", d2_flush, 1);
    check("fb_res1_pc", d2_pc, 1);
    check("fb_res_d1", d1_flush, 1);
    check("fb_cnt_d2", d2_cnt, 7);
    check("fb_cnt_d0", d0_cnt, 5);
    next_cycle(); #1;
    check("fb_res2_flush", d2_flush, 1);
    check("fb_d1_done", d1_flush, 0);
    next_cycle(); #1;
    check("fb_done", d2_flush, 0);

    // Reset in the second cycle of a 3-cycle load stall.
    next_cycle(); load_use_a3(); #1;
    check("rs_c1_pc", d1_pc, 0);
    next_cycle(); clr(); reset = 1'b1; #1;
    check("rs_in_pc", d1_pc, 1);
    check("rs_in_bub", d1_bub, 0);
    next_cycle(); reset = 1'b0; #1;
    check("rs_after_pc", d1_pc, 1);
    check("rs_after_bub", d1_bub, 0);
    check("rs_after_cnt", d1_cnt, 0);

    // Saturation: 20 busy cycles, 4-bit counter stops at 15.
    for (int i = 0; i < 20; i++) begin
      next_cycle(); mem_busy = 1'b1; #1;
      if (i == 0) check("sat_pc", d2_pc, 0);
      if (i == 15) check("sat_cnt15", d2_cnt, 15);
    end
    next_cycle(); mem_busy = 1'b0; #1;
    check("sat_cnt_d2", d2_cnt, 15);
    check("sat_cnt_d0", d0_cnt, 20);
    check("sat_resume_pc", d2_pc, 1);
    check("sat_resume_ifid", d0_ifid, 1);
    next_cycle(); #1;
    check("sat_hold_d2", d2_cnt, 15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard sequencer for the 8-bit, 5-stage pipelined CPU.
- Watches the register addresses in ID, EX, MEM and WB, the branch-taken flush from the ID stage, and the data-memory busy flag.
- Drives the PC and IF/ID enables, the IF/ID flush, the ID/EX bubble insert, and the two 2-bit forwarding selects consumed by the EX operand muxes.
- Keeps a saturating stall-cycle counter for debug.

Parameters:
- LOAD_LATENCY, 1, total stall cycles for a load-use hazard (1..3).
- FLUSH_CYCLES, 1, IF/ID flush cycles after a taken branch (1..3).
- CNT_W, 8, width of stall_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- id_a_addr  in  4  source A register of the instruction in ID.
- id_b_addr  in  4  source B register of the instruction in ID.
- id_uses_a  in  1  instruction in ID reads A.
- id_uses_b  in  1  instruction in ID reads B.
- ex_w_addr  in  4  destination register in EX.
- ex_reg_write  in  1  instruction in EX writes the register file.
- ex_mem_read  in  1  instruction in EX is a load.
- mem_w_addr  in  4  destination register in MEM.
- mem_reg_write  in  1  instruction in MEM writes the register file.
- wb_w_addr  in  4  destination register in WB.
- wb_reg_write  in  1  instruction in WB writes the register file.
- branch_taken  in  1  taken-branch flush request from ID.
- mem_busy  in  1  data memory not ready; the whole pipe must freeze.
- pc_enable  out  1  PC may update.
- if_id_enable  out  1  IF/ID register may load.
- if_id_flush  out  1  clear IF/ID to a NOP.
- id_ex_bubble  out  1  load a NOP (all control bits 0) into ID/EX.
- fwd_a  out  2  EX operand A select: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
- fwd_b  out  2  EX operand B select, same encoding as fwd_a.
- stall_count  out  CNT_W  saturating count of cycles with pc_enable=0.

Behaviour:
- State and counters are registered. Control outputs are combinational (Mealy) from the state and the current inputs, so a hazard acts in the same cycle it is detected.
- States:
  - RUN.
  - LOAD_STALL: holds remaining load-stall cycles in a down-counter.
  - FLUSH: holds remaining flush cycles in a down-counter.
  - MEM_WAIT.
- Reset:
  - state=RUN, counters=0, stall_count=0.
  - During the reset cycle outputs are pc_enable=1, if_id_enable=1, if_id_flush=0, id_ex_bubble=0, fwd_a=00, fwd_b=00.
  - Reset asserted mid-stall or mid-flush abandons that operation immediately.
- load_use = ex_mem_read & ex_reg_write & ((id_uses_a & id_a_addr==ex_w_addr) | (id_uses_b & id_b_addr==ex_w_addr)).
- Event priority, highest first: reset > mem_busy > branch_taken > load_use.
- RUN:
  - mem_busy: pc_enable=0, if_id_enable=0, no bubble, no flush. Go to MEM_WAIT.
  - Else branch_taken: if_id_flush=1, pc_enable=1. If FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1.
  - Else load_use: pc_enable=0, if_id_enable=0, id_ex_bubble=1. If LOAD_LATENCY>1, go to LOAD_STALL with counter=LOAD_LATENCY-1.
- LOAD_STALL:
  - Same outputs as a load-use stall; decrement the counter; return to RUN when the counter reaches 0.
  - mem_busy pre-empts: go to MEM_WAIT and discard the remaining count.
- FLUSH:
  - if_id_flush=1; decrement; return to RUN at 0.
  - mem_busy pre-empts: the pipe freezes, the counter holds, and FLUSH resumes once mem_busy drops.
- MEM_WAIT:
  - All stage enables 0, bubble 0, flush 0.
  - Return to the saved resume state (RUN or FLUSH) in the first cycle that mem_busy=0. Outputs in that cycle follow the resumed state's rules.
- branch_taken together with load_use: the flush wins and no bubble is inserted, because the ID instruction is discarded.
- Forwarding (combinational, every state):
  - fwd_x=01 if mem_reg_write & mem_w_addr==id_x_addr.
  - Else fwd_x=10 if wb_reg_write & wb_w_addr==id_x_addr.
  - Else 00.
  - MEM beats WB when both match.
  - Register 0 is not special.
- stall_count increments on every clock with pc_enable=0 and saturates at all-ones; no wrap.

Decomposition:
- Shared package:
  - State encoding constants RUN=2'd0, LOAD_STALL=2'd1, FLUSH=2'd2, MEM_WAIT=2'd3.
  - Forwarding select constants FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
- One natural sub-module, fwd_select: purely combinational; one instance per operand (A, B).

Test Plan:
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_w_addr=4'h3, id_a_addr=4'h3, id_uses_a=1 -> exactly 1 cycle of pc_enable=0, if_id_enable=0, id_ex_bubble=1; stall_count=1. With LOAD_LATENCY=3 -> 3 cycles.
- Forwarding priority: mem_w_addr=wb_w_addr=4'h5, both reg_write=1, id_b_addr=4'h5 -> fwd_b=01. Drop mem_reg_write -> fwd_b=10. Set wb_w_addr=4'h6 -> fwd_b=00.
- Branch plus load-use in the same cycle -> if_id_flush=1, id_ex_bubble=0, pc_enable=1. With FLUSH_CYCLES=2 -> flush held 2 cycles.
- mem_busy held 4 cycles during FLUSH (FLUSH_CYCLES=3, 1 cycle done) -> 4 frozen cycles, then 2 further flush cycles; stall_count +4.
- Reset asserted in the 2nd LOAD_STALL cycle (LOAD_LATENCY=3) -> next cycle state=RUN, pc_enable=1, stall_count=0.
- Saturation: CNT_W=4, 20 consecutive mem_busy cycles -> stall_count stops at 4'hF.
